// File: rtl/lzd_norm_arbiter.sv
// Shared leading-zero-detect / normalise unit with a round-robin front end.
// Requesters are arbitrated into a stage-1 register; stage 2 holds the normalised result.
module lzd_norm_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  localparam int S   = $clog2(N),
  localparam int IW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_data,
  output logic [S-1:0]      out_lzc,
  output logic              out_zero,
  output logic [IW-1:0]     out_id
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
  // valid must stay asserted until that edge, ready may depend on valid.

  logic [N-1:0]  req_word [NREQ];
  logic          s1_valid;
  logic [N-1:0]  s1_data;
  logic [IW-1:0] s1_id;
  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_next;
  logic          s1_adv;
  logic          s1_acc;
  logic          grant_any;
  logic [IW-1:0] grant_id;
  logic [NREQ-1:0] grant_vec;
  logic [IW:0]   cand;
  logic [N-1:0]  norm_v;
  logic [S-1:0]  norm_lz;
  logic          s1_zero;

  for (genvar i = 0; i < NREQ; i++) begin : g_split
    assign req_word[i] = req_data[i*N +: N];
  end

  assign s1_adv = s1_valid & (~out_valid | out_ready);
  assign s1_acc = ~s1_valid | s1_adv;

  // Search from the pointer upward; cand stays below NREQ so non-power-of-two counts wrap.
  always_comb begin
    grant_vec = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = {1'b0, ptr} + (IW+1)'(off);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (!grant_any && rst_n && s1_acc && req_valid[cand[IW-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = cand[IW-1:0];
      end
    end
    if (grant_any) begin
      grant_vec[grant_id] = 1'b1;
    end
  end

  assign req_ready = grant_vec;
  assign ptr_next  = (grant_id == IW'(NREQ-1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_id    <= '0;
      ptr      <= '0;
    end else if (s1_acc) begin
      s1_valid <= grant_any;
      if (grant_any) begin
        s1_data <= req_word[grant_id];
        s1_id   <= grant_id;
        ptr     <= ptr_next;
      end
    end
  end

  // Binary-search normaliser: each step shifts by 2^k when the top 2^k bits are clear.
  always_comb begin
    norm_v  = s1_data;
    norm_lz = '0;
    for (int k = S-1; k >= 0; k--) begin
      if ((norm_v & ~({N{1'b1}} >> (1 << k))) == '0) begin
        norm_v     = norm_v << (1 << k);
        norm_lz[k] = 1'b1;
      end
    end
  end

  assign s1_zero = (s1_data == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lzc   <= '0;
      out_zero  <= 1'b0;
      out_id    <= '0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      out_data  <= s1_zero ? '0 : norm_v;
      out_lzc   <= s1_zero ? '0 : norm_lz;
      out_zero  <= s1_zero;
      out_id    <= s1_id;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lzd_norm_arbiter.sv
// Bench for lzd_norm_arbiter: directed vector table, multi-cycle sequences and
// randomized traffic checked against a transaction-level model with an expected queue.
module tb_lzd_norm_arbiter;
  localparam int N = 32;
  localparam int NREQ = 4;
  localparam int S = 5;
  localparam int IW = 2;
  localparam int W = IW + N;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      out_data;
  logic [S-1:0]      out_lzc;
  logic              out_zero;
  logic [IW-1:0]     out_id;
  logic [N-1:0]      dat [NREQ];

  lzd_norm_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_lzc(out_lzc), .out_zero(out_zero), .out_id(out_id)
  );

  // clock / reset
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) req_data[i*N +: N] = dat[i];
  end

  int n_tests = 0;
  int n_fail = 0;

  // transaction model state and scoreboard
  bit             m_s1, m_out;
  int             m_ptr;
  logic [W-1:0]   exp_q[$];
  bit             keep_all;
  int             last_grant;
  bit             popped;
  logic [N-1:0]   obs_data;
  int             obs_lzc;
  bit             obs_zero;
  int             obs_id;

  typedef struct {
    int         id;
    logic [N-1:0] din;
    logic [N-1:0] exp_data;
    int         exp_lzc;
    bit         exp_zero;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_lzc(input logic [N-1:0] x);
    int n;
    n = 0;
    if (x == '0) return 0;
    while (x[N-1-n] == 1'b0) n++;
    return n;
  endfunction

  function automatic logic [N-1:0] rand_word();
    logic [N-1:0] w;
    case ($urandom_range(0, 3))
      0: w = $urandom;
      1: w = $urandom >> $urandom_range(0, 31);
      2: w = 32'h1 << $urandom_range(0, 31);
      default: w = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'hFFFF_FFFF;
    endcase
    return w;
  endfunction

  // driver: one clock cycle, called and returning at a negedge
  task automatic step();
    int g;
    bit acc, adv;
    logic [W-1:0] e;
    #1;
    adv = m_s1 && (!m_out || out_ready);
    acc = !m_s1 || adv;
    g = -1;
    if (acc) begin
      for (int off = 0; off < NREQ; off++) begin
        int i;
        i = (m_ptr + off) % NREQ;
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    check("req_ready", 64'(req_ready), (g < 0) ? 64'h0 : (64'h1 << g));
    check("out_valid", 64'(out_valid), 64'(m_out));
    popped = 1'b0;
    if (m_out) begin
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'h1);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        check("out_data", 64'(out_data), 64'(e[N-1:0] << ref_lzc(e[N-1:0])));
        check("out_lzc", 64'(out_lzc), 64'(ref_lzc(e[N-1:0])));
        check("out_zero", 64'(out_zero), 64'(e[N-1:0] == '0));
        check("out_id", 64'(out_id), 64'(e[W-1:N]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          popped = 1'b1;
          obs_data = out_data;
          obs_lzc = int'(out_lzc);
          obs_zero = out_zero;
          obs_id = int'(out_id);
        end
      end
    end
    last_grant = g;
    if (g >= 0) exp_q.push_back({IW'(g), dat[g]});
    @(posedge clk);
    m_out = adv ? 1'b1 : (out_ready ? 1'b0 : m_out);
    if (acc) m_s1 = (g >= 0);
    if (g >= 0) m_ptr = (g + 1) % NREQ;
    @(negedge clk);
    if (g >= 0) begin
      if (keep_all) dat[g] = rand_word();
      else req_valid[g] = 1'b0;
    end
  endtask

  task automatic model_clear();
    m_s1 = 1'b0;
    m_out = 1'b0;
    m_ptr = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_out_lzc", 64'(out_lzc), 64'h0);
    check("rst_out_zero", 64'(out_zero), 64'h0);
    check("rst_out_id", 64'(out_id), 64'h0);
    req_valid = '0;
    keep_all = 1'b0;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic drain();
    int n;
    req_valid = '0;
    keep_all = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || m_out) && n < 12) begin
      step();
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rr_exp [3];
    logic [N-1:0] hold;
    rst_n = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    keep_all = 1'b0;
    for (int i = 0; i < NREQ; i++) dat[i] = '0;
    model_clear();

    tbl[0] = '{0, 32'h0000_1234, 32'h91A0_0000, 19, 1'b0};
    tbl[1] = '{2, 32'h0000_0000, 32'h0000_0000, 0, 1'b1};
    tbl[2] = '{2, 32'h8000_0000, 32'h8000_0000, 0, 1'b0};
    tbl[3] = '{2, 32'h0000_0001, 32'h8000_0000, 31, 1'b0};
    tbl[4] = '{1, 32'h00FF_0000, 32'hFF00_0000, 8, 1'b0};
    tbl[5] = '{3, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1, 1'b0};
    tbl[6] = '{0, 32'h0000_0003, 32'hC000_0000, 30, 1'b0};
    tbl[7] = '{1, 32'h0001_0000, 32'h8000_0000, 15, 1'b0};

    // directed vector table
    do_reset();
    for (int v = 0; v < 8; v++) begin
      req_valid = '0;
      dat[tbl[v].id] = tbl[v].din;
      req_valid[tbl[v].id] = 1'b1;
      out_ready = 1'b1;
      n = 0;
      popped = 1'b0;
      while (!popped && n < 10) begin
        step();
        if (n == 0) check("tbl_grant", 64'(last_grant), 64'(tbl[v].id));
        n++;
      end
      check("tbl_done", 64'(popped), 64'h1);
      if (v == 0) check("first_latency", 64'(n), 64'h3);
      if (popped) begin
        check("tbl_data", 64'(obs_data), 64'(tbl[v].exp_data));
        check("tbl_lzc", 64'(obs_lzc), 64'(tbl[v].exp_lzc));
        check("tbl_zero", 64'(obs_zero), 64'(tbl[v].exp_zero));
        check("tbl_id", 64'(obs_id), 64'(tbl[v].id));
      end
    end
    drain();

    // round-robin with all requesters valid
    do_reset();
    for (int i = 0; i < NREQ; i++) dat[i] = rand_word();
    req_valid = '1;
    keep_all = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("rr_grant", 64'(last_grant), 64'(k % NREQ));
    end
    drain();

    // backpressure: hold the result for five cycles, then resume
    do_reset();
    for (int i = 0; i < NREQ; i++) dat[i] = rand_word();
    req_valid = '1;
    keep_all = 1'b1;
    out_ready = 1'b1;
    repeat (2) step();
    out_ready = 1'b0;
    hold = out_data;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_hold", 64'(out_data), 64'(hold));
      check("bp_no_grant", 64'(req_ready), 64'h0);
    end
    out_ready = 1'b1;
    repeat (6) step();
    drain();

    // fairness: only requesters 1 and 3 request
    do_reset();
    for (int i = 0; i < NREQ; i++) dat[i] = rand_word();
    req_valid = 4'b1010;
    keep_all = 1'b1;
    out_ready = 1'b1;
    rr_exp = '{1, 3, 1};
    for (int k = 0; k < 3; k++) begin
      step();
      check("fair_grant", 64'(last_grant), 64'(rr_exp[k]));
    end
    for (int k = 0; k < 3; k++) begin
      step();
      check("fair_skip", 64'(last_grant == 0 || last_grant == 2), 64'h0);
    end
    drain();

    // reset with both stages full
    do_reset();
    for (int i = 0; i < NREQ; i++) dat[i] = rand_word();
    req_valid = '1;
    keep_all = 1'b1;
    out_ready = 1'b0;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'h0);
    check("arst_req_ready", 64'(req_ready), 64'h0);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("arst_first_grant", 64'(last_grant), 64'h0);
    repeat (3) step();
    drain();

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          dat[i] = rand_word();
          req_valid[i] = 1'b1;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lzd_norm_arbiter.md
Name: lzd_norm_arbiter

Overview:
- Shares one leading-zero-detect + normalise-shift unit between NREQ requesters in the posit/float conversion datapath.
- Requesters present N-bit magnitudes on valid/ready ports. A round-robin arbiter grants one per cycle.
- A two-stage pipeline returns the left-normalised value, the leading-zero count, a zero flag and the requester id.
- Used by the converters so that multiple regime/fraction normalisers do not each instantiate their own LZD and barrel shifter.

Parameters:
- N, 32, operand width; power of two, >= 4.
- NREQ, 4, number of requesters; >= 2.
- S, clog2(N), leading-zero-count width (derived; not overridden).
- IW, clog2(NREQ), requester id width (derived).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester valid.
- req_data  input  NREQ*N  requester i occupies bits [i*N +: N].
- req_ready  output  NREQ  one-hot grant; requester i transfers when req_valid[i] & req_ready[i].
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  N  input shifted left by the leading-zero count (MSB = 1 unless zero).
- out_lzc  output  S  number of leading zeros from the MSB.
- out_zero  output  1  input was all zeros.
- out_id  output  IW  index of the requester that produced the result.

Behaviour:
- Reset (async assert, sync-safe deassert): out_valid=0, out_data=0, out_lzc=0, out_zero=0, out_id=0, stage-1 valid=0, round-robin pointer=0. req_ready is 0 while rst_n=0.
- Stage 1 register (s1) holds the granted data and id. Stage 2 is the output register.
- s1_adv = s1_valid & (~out_valid | out_ready).
- s1_acc = ~s1_valid | s1_adv.
- Arbitration is combinational. When s1_acc=1, grant the first i with req_valid[i]=1, searching from pointer upward with wrap-around. req_ready is one-hot for that i; otherwise req_ready=0.
- req_ready may depend on req_valid. A requester must not drop req_valid before it is granted.
- On a grant to requester g: capture the data and id into s1 and set pointer=(g+1) mod NREQ. The pointer is unchanged when there is no grant. NREQ that is not a power of two wraps correctly.
- Stage 2, on s1_adv: compute the LZD and shift on the s1 data and load the output registers, out_valid=1.
  - Else, if out_ready: out_valid=0. Data outputs hold their last values.
- Outputs are stable while out_valid & ~out_ready.
- Latency: a request accepted at edge k appears with out_valid=1 after edge k+1. Throughput is one result per cycle with out_ready held high.
- Zero input: out_zero=1, out_lzc=0, out_data=0.
- Non-zero input: out_zero=0, out_lzc in 0..N-1, out_data = data << out_lzc.
- Backpressure: when out_valid & ~out_ready and s1 is full, s1_acc=0 and no grants are issued. Requests wait without loss or duplication.
- Simultaneous out_ready and a new s1 result in the same cycle: the new result replaces the old one with no bubble.
- Reset mid-operation clears both stages. In-flight results are discarded, never emitted.

Test Plan:
- Reset then a single request: req_valid=4'b0001, data0=32'h0000_1234 -> req_ready=0001. Two edges later: out_valid=1, out_lzc=19, out_data=32'h91A0_0000, out_zero=0, out_id=0.
- Zero operand: requester 2 sends 32'h0 -> out_zero=1, out_lzc=0, out_data=0, out_id=2.
  - Also send 32'h8000_0000 -> out_lzc=0, out_data=32'h8000_0000.
  - Also send 32'h1 -> out_lzc=31, out_data=32'h8000_0000.
- Round-robin: all four requesters valid continuously, out_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles. out_id follows the same order two cycles later, one result per cycle.
- Backpressure: out_ready=0 for 5 cycles with all requesters valid -> one result held stable, s1 full, req_ready=0. On release, results resume in order with none lost or duplicated (scoreboard check).
- Fairness skip: req_valid=4'b1010 with pointer=0 -> grant 1, then 3, then 1. Requesters 0 and 2 are never granted.
- Reset during activity: assert rst_n=0 with both stages full -> out_valid drops to 0 immediately (asynchronously). After release, the first grant goes to requester 0 and no stale result appears.
